// File: rtl/led_bar_sequencer_pkg.sv
// led_pkg: shared state encoding and default sizing for the LED bar sequencer
package led_pkg;
    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2,
        ST_PAUSE      = 2'd3
    } state_t;
    localparam int LED_W_DEF     = 9;
    localparam int MAX_LEVEL_DEF = 8;
endpackage

// File: rtl/led_bar_sequencer_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV running cycles
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    assign tick = run && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else if (run)
            cnt <= cnt + CW'(1);
endmodule

// File: rtl/led_bar_sequencer.sv
// led_bar_sequencer: manual / ping-pong sweep controller driving a thermometer LED bar
module led_bar_sequencer
    import led_pkg::*;
#(
    parameter int LED_W     = LED_W_DEF,
    parameter int MAX_LEVEL = MAX_LEVEL_DEF,
    parameter int TICK_DIV  = 25_000_000,
    parameter int LVL_W     = $clog2(MAX_LEVEL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    input  logic             mode_pulse,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       state,
    output logic [LED_W-1:0] LEDS
);
    localparam logic [LVL_W-1:0] LMAX = LVL_W'(MAX_LEVEL);
    localparam logic [LVL_W-1:0] ONE  = LVL_W'(1);
    state_t           st;
    logic             tick, run, clear, inc_only, dec_only;
    logic [LED_W-1:0] therm;
    assign inc_only = inc_pulse && !dec_pulse;
    assign dec_only = dec_pulse && !inc_pulse;
    assign run      = (st == ST_SWEEP_UP || st == ST_SWEEP_DOWN) && !mode_pulse;
    // Every entry into a sweep restarts the prescaler so the first step is a full period away
    assign clear    = (st == ST_MANUAL && mode_pulse) || (st == ST_PAUSE && !mode_pulse && (inc_only || dec_only));
    assign state    = st;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );
    always_comb begin
        therm = '0;
        for (int i = 0; i < LED_W; i++) therm[i] = i < int'(level);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_MANUAL;
            level <= '0;
            LEDS  <= '0;
        end else begin
            LEDS <= therm;
            case (st)
                ST_MANUAL:
                    if (mode_pulse) st <= ST_SWEEP_UP;
                    else if (inc_only) level <= (level == LMAX) ? '0 : level + ONE;
                    else if (dec_only) level <= (level == '0) ? LMAX : level - ONE;
                ST_SWEEP_UP:
                    if (mode_pulse) st <= ST_PAUSE;
                    else if (tick && level == LMAX) begin
                        st    <= ST_SWEEP_DOWN;
                        level <= LMAX - ONE;
                    end else if (tick) level <= level + ONE;
                ST_SWEEP_DOWN:
                    if (mode_pulse) st <= ST_PAUSE;
                    else if (tick && level == '0) begin
                        st    <= ST_SWEEP_UP;
                        level <= ONE;
                    end else if (tick) level <= level - ONE;
                default:
                    if (mode_pulse) st <= ST_MANUAL;
                    else if (inc_only) st <= ST_SWEEP_UP;
                    else if (dec_only) st <= ST_SWEEP_DOWN;
            endcase
        end
    end
endmodule

// File: tb/tb_led_bar_sequencer.sv
// tb_led_bar_sequencer: directed vectors for manual, sweep, pause and reset behaviour
module tb_led_bar_sequencer;
    logic       clk = 1'b0, reset = 1'b1, inc_pulse = 1'b0, dec_pulse = 1'b0, mode_pulse = 1'b0;
    logic [3:0] level;
    logic [1:0] state;
    logic [8:0] LEDS;
    int         total = 0, bad = 0;
    logic [3:0] prev_el = 4'd0;
    logic [3:0] cur_l;
    logic [1:0] cur_s;

    typedef struct {
        logic       i, d, m;
        logic [3:0] l;
        logic [1:0] s;
    } vec_t;
    vec_t tbl [15];
    int sw_l [19] = '{7, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 7};
    int sw_s [19] = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 2};

    led_bar_sequencer #(.LED_W(9), .MAX_LEVEL(8), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .mode_pulse (mode_pulse),
        .level      (level),
        .state      (state),
        .LEDS       (LEDS)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] therm(input logic [3:0] l);
        return (9'd1 << l) - 9'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of pulses, then check the registered outputs just after the edge
    task automatic cyc(input logic i, input logic d, input logic m,
                       input logic [3:0] el, input logic [1:0] es, input string nm);
        inc_pulse  = i;
        dec_pulse  = d;
        mode_pulse = m;
        @(posedge clk);
        #1;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        mode_pulse = 1'b0;
        chk({nm, " level"}, 32'(level), 32'(el));
        chk({nm, " state"}, 32'(state), 32'(es));
        chk({nm, " LEDS"}, 32'(LEDS), 32'(therm(prev_el)));
        chk({nm, " LEDS8"}, 32'(LEDS[8]), 32'd0);
        prev_el = el;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tbl[k] = '{1'b1, 1'b0, 1'b0, 4'(k + 1), 2'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'd8, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd8, 2'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd7, 2'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd6, 2'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 4'd6, 2'd1};

        #1;
        chk("reset level", 32'(level), 32'd0);
        chk("reset state", 32'(state), 32'd0);
        chk("reset LEDS", 32'(LEDS), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            cyc(tbl[k].i, tbl[k].d, tbl[k].m, tbl[k].l, tbl[k].s, $sformatf("vec%0d", k));
            if (k == 10) chk("LEDS full", 32'(LEDS), 32'h0ff);
        end

        cur_l = 4'd6;
        cur_s = 2'd1;
        for (int s = 0; s < 19; s++) begin
            cyc(1'b1, 1'b0, 1'b0, cur_l, cur_s, "sweep ign inc");
            cyc(1'b0, 1'b1, 1'b0, cur_l, cur_s, "sweep ign dec");
            cyc(1'b0, 1'b0, 1'b0, cur_l, cur_s, "sweep idle");
            cur_l = 4'(sw_l[s]);
            cur_s = 2'(sw_s[s]);
            cyc(1'b0, 1'b0, 1'b0, cur_l, cur_s, $sformatf("sweep step%0d", s));
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd7, 2'd2, "pre pause");
        cyc(1'b0, 1'b0, 1'b1, 4'd7, 2'd3, "pause on tick");
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 4'd7, 2'd3, "pause hold");
        cyc(1'b0, 1'b1, 1'b0, 4'd7, 2'd2, "resume down");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd7, 2'd2, "resume wait");
        cyc(1'b0, 1'b0, 1'b0, 4'd6, 2'd2, "resume step");
        cyc(1'b0, 1'b0, 1'b1, 4'd6, 2'd3, "pause again");
        cyc(1'b1, 1'b1, 1'b0, 4'd6, 2'd3, "pause both");
        cyc(1'b1, 1'b0, 1'b0, 4'd6, 2'd1, "resume up");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd6, 2'd1, "up wait");
        cyc(1'b0, 1'b0, 1'b0, 4'd7, 2'd1, "up step");
        cyc(1'b0, 1'b0, 1'b1, 4'd7, 2'd3, "to pause");
        cyc(1'b0, 1'b0, 1'b1, 4'd7, 2'd0, "to manual");
        cyc(1'b0, 1'b1, 1'b0, 4'd6, 2'd0, "man dec");
        cyc(1'b0, 1'b1, 1'b0, 4'd5, 2'd0, "man dec");
        cyc(1'b0, 1'b0, 1'b1, 4'd5, 2'd1, "sweep at 5");
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd5, 2'd1, "sweep at 5 wait");

        #2 reset = 1'b1;
        #1;
        chk("async level", 32'(level), 32'd0);
        chk("async state", 32'(state), 32'd0);
        chk("async LEDS", 32'(LEDS), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_el = 4'd0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, "post reset idle");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 2'd1, "post reset sweep");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0, 2'd1, "post reset wait");
        cyc(1'b0, 1'b0, 1'b0, 4'd1, 2'd1, "post reset step");
        cyc(1'b0, 1'b0, 1'b0, 4'd1, 2'd1, "post reset lag");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
